// File: rtl/icmp_pkg.sv
// icmp_pkg: shared constants, FSM state type and ones-complement helper for the ICMP echo responder
package icmp_pkg;
    localparam logic [7:0] PROTO_ICMP        = 8'h01;
    localparam logic [7:0] ICMP_ECHO_REQUEST = 8'h08;
    localparam logic [7:0] ICMP_ECHO_REPLY   = 8'h00;
    localparam int         IP_HDR_BYTES      = 20;
    localparam int         ICMP_HDR_BYTES    = 8;

    typedef enum logic [2:0] {IDLE, RX, CHECK, TX_HDR, TX_PAY, DROP} icmp_state_t;

    // 16-bit ones-complement add; the end-around carry can never overflow twice
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction
endpackage

// File: rtl/ip_intf.sv
// ip_intf: IP header + byte-wide payload stream between protocol blocks
//   ip_hdr_*      header valid/ready handshake and header fields
//   ip_payload_*  AXI-stream style payload (tdata/tvalid/tready/tlast/tuser)
interface ip_intf #(parameter int DATA_WIDTH = 8);
    logic                  ip_hdr_valid;
    logic                  ip_hdr_ready;
    logic [5:0]            ip_dscp;
    logic [1:0]            ip_ecn;
    logic [15:0]           ip_length;
    logic [7:0]            ip_ttl;
    logic [7:0]            ip_protocol;
    logic [31:0]           ip_source_ip;
    logic [31:0]           ip_dest_ip;
    logic [DATA_WIDTH-1:0] ip_payload_tdata;
    logic                  ip_payload_tvalid;
    logic                  ip_payload_tready;
    logic                  ip_payload_tlast;
    logic                  ip_payload_tuser;

    modport MASTER (
        output ip_hdr_valid, ip_dscp, ip_ecn, ip_length, ip_ttl, ip_protocol,
               ip_source_ip, ip_dest_ip, ip_payload_tdata, ip_payload_tvalid,
               ip_payload_tlast, ip_payload_tuser,
        input  ip_hdr_ready, ip_payload_tready
    );
    modport SLAVE (
        input  ip_hdr_valid, ip_dscp, ip_ecn, ip_length, ip_ttl, ip_protocol,
               ip_source_ip, ip_dest_ip, ip_payload_tdata, ip_payload_tvalid,
               ip_payload_tlast, ip_payload_tuser,
        output ip_hdr_ready, ip_payload_tready
    );
endinterface

// File: rtl/icmp_payload_buffer.sv
// icmp_payload_buffer: simple dual-port RAM, one write port and a registered read port
//   clk      clock
//   we       write enable, wr_addr/wr_data write port
//   rd_en    read enable; rd_data holds its value while rd_en is low
//   rd_addr  read address, rd_data valid one cycle after rd_en
module icmp_payload_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/icmp_echo_responder.sv
// icmp_echo_responder: answers ICMP echo requests with echo replies, drops all other ICMP
//   i_clk, i_rst   clock, synchronous active-high reset
//   s_ip           ICMP datagrams from the IP demux
//   m_ip           echo replies towards the IP arbitrating mux
//   o_reply_count  replies fully sent (wrapping)
//   o_drop_count   messages discarded (wrapping)
module icmp_echo_responder
    import icmp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 1024,
    parameter int REPLY_TTL  = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ip_intf.SLAVE        s_ip,
    ip_intf.MASTER       m_ip,
    output logic [15:0]  o_reply_count,
    output logic [15:0]  o_drop_count
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("icmp_echo_responder: DATA_WIDTH must be 8");
    end
    if ((1 << AW) != BUF_DEPTH) begin : g_bad_depth
        $error("icmp_echo_responder: BUF_DEPTH must be a power of two");
    end

    icmp_state_t     state, state_nx;
    logic [31:0]     src_ip, dst_ip;
    logic [CW-1:0]   cnt, idx;
    logic [7:0]      icmp_type, icmp_code;
    logic [15:0]     hc, csum;
    logic            bad_tuser, s_hs, m_hs, last_byte, drop_msg, rd_en;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_data;
    logic            unused_hdr;

    assign s_hs      = s_ip.ip_payload_tvalid && s_ip.ip_payload_tready;
    assign m_hs      = m_ip.ip_payload_tvalid && m_ip.ip_payload_tready;
    assign last_byte = idx == cnt - 1'b1;
    assign drop_msg  = bad_tuser || cnt < CW'(ICMP_HDR_BYTES) ||
                       icmp_type != ICMP_ECHO_REQUEST || icmp_code != 8'h00;
    assign unused_hdr = ^{s_ip.ip_dscp, s_ip.ip_ecn, s_ip.ip_length, s_ip.ip_ttl};

    assign s_ip.ip_hdr_ready      = state == IDLE;
    assign s_ip.ip_payload_tready = state == RX || state == DROP;

    assign m_ip.ip_hdr_valid      = state == TX_HDR;
    assign m_ip.ip_dscp           = 6'd0;
    assign m_ip.ip_ecn            = 2'd0;
    assign m_ip.ip_ttl            = 8'(REPLY_TTL);
    assign m_ip.ip_protocol       = PROTO_ICMP;
    assign m_ip.ip_source_ip      = dst_ip;
    assign m_ip.ip_dest_ip        = src_ip;
    assign m_ip.ip_length         = 16'(IP_HDR_BYTES) + 16'(cnt);
    assign m_ip.ip_payload_tvalid = state == TX_PAY;
    assign m_ip.ip_payload_tlast  = last_byte;
    assign m_ip.ip_payload_tuser  = 1'b0;
    assign m_ip.ip_payload_tdata  = idx == CW'(0) ? ICMP_ECHO_REPLY :
                                    idx == CW'(1) ? 8'h00 :
                                    idx == CW'(2) ? csum[15:8] :
                                    idx == CW'(3) ? csum[7:0] : rd_data;

    // rd_data only advances on a payload handshake, so it always holds byte idx
    // once idx >= 4; the read of byte 4 is issued in CHECK
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        rd_addr  = AW'(idx + 1'b1);
        case (state)
            IDLE:    if (s_ip.ip_hdr_valid) state_nx = s_ip.ip_protocol == PROTO_ICMP ? RX : DROP;
            RX:      if (s_hs) state_nx = s_ip.ip_payload_tlast ? CHECK :
                                          cnt == CW'(BUF_DEPTH - 1) ? DROP : RX;
            CHECK: begin
                state_nx = drop_msg ? IDLE : TX_HDR;
                rd_en    = !drop_msg;
                rd_addr  = AW'(4);
            end
            TX_HDR:  if (m_ip.ip_hdr_ready) state_nx = TX_PAY;
            TX_PAY: begin
                rd_en = m_hs && idx >= CW'(4);
                if (m_hs && last_byte) state_nx = IDLE;
            end
            DROP:    if (s_hs && s_ip.ip_payload_tlast) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            bad_tuser     <= 1'b0;
            o_reply_count <= '0;
            o_drop_count  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && s_ip.ip_hdr_valid) begin
                src_ip <= s_ip.ip_source_ip;
                dst_ip <= s_ip.ip_dest_ip;
                cnt    <= '0;
            end
            if (state == RX && s_hs) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(0)) icmp_type <= s_ip.ip_payload_tdata;
                if (cnt == CW'(1)) icmp_code <= s_ip.ip_payload_tdata;
                if (cnt == CW'(2)) hc[15:8]  <= s_ip.ip_payload_tdata;
                if (cnt == CW'(3)) hc[7:0]   <= s_ip.ip_payload_tdata;
                if (s_ip.ip_payload_tlast) bad_tuser <= s_ip.ip_payload_tuser;
            end
            if (state == CHECK) begin
                csum <= ~ones_add16(~hc, 16'hF7FF);
                idx  <= '0;
            end
            if (state == TX_PAY && m_hs) idx <= idx + 1'b1;
            if (state == TX_PAY && m_hs && last_byte) o_reply_count <= o_reply_count + 1'b1;
            if ((state == CHECK && drop_msg) || (state == DROP && s_hs && s_ip.ip_payload_tlast))
                o_drop_count <= o_drop_count + 1'b1;
        end
    end

    icmp_payload_buffer #(.WIDTH(8), .DEPTH(BUF_DEPTH)) u_buf (
        .clk     (i_clk),
        .we      (state == RX && s_hs),
        .wr_addr (cnt[AW-1:0]),
        .wr_data (s_ip.ip_payload_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb_icmp_echo_responder: scoreboard bench for the ICMP echo responder
module tb_icmp_echo_responder;
    localparam int DEPTH = 128;
    localparam int TMO   = 3000;
    localparam logic [31:0] IP_A = 32'hAC00_0005;
    localparam logic [31:0] IP_B = 32'hAC00_0002;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reply_count, drop_count;

    ip_intf #(.DATA_WIDTH(8)) s_if ();
    ip_intf #(.DATA_WIDTH(8)) m_if ();

    icmp_echo_responder #(.DATA_WIDTH(8), .BUF_DEPTH(DEPTH), .REPLY_TTL(64)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .s_ip          (s_if),
        .m_ip          (m_if),
        .o_reply_count (reply_count),
        .o_drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    hdr_t       exp_hdr[$];
    logic [8:0] exp_pay[$];
    logic [7:0] frm[$];
    int         n_cmp = 0, n_bad = 0, pay_seen = 0, rep_exp = 0, drop_exp = 0;
    bit         sink_hold = 0, sink_rand = 0, prev_stall = 0;
    logic [9:0] prev_pay;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cks_model(input logic [15:0] c);
        logic [31:0] t;
        t = {16'd0, ~c} + 32'h0000_F7FF;
        t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
        return ~t[15:0];
    endfunction

    task automatic build(input logic [7:0] typ, input logic [7:0] code, input logic [15:0] c, input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
        if (len > 0) frm[0] = typ;
        if (len > 1) frm[1] = code;
        if (len > 2) frm[2] = c[15:8];
        if (len > 3) frm[3] = c[7:0];
    endtask

    task automatic push_reply(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] c);
        hdr_t h;
        h.src = dst;
        h.dst = src;
        h.len = 16'(20 + frm.size());
        exp_hdr.push_back(h);
        exp_pay.push_back({1'b0, 8'h00});
        exp_pay.push_back({1'b0, 8'h00});
        exp_pay.push_back({1'b0, c[15:8]});
        exp_pay.push_back({1'b0, c[7:0]});
        for (int i = 4; i < frm.size(); i++) exp_pay.push_back({i == frm.size() - 1, frm[i]});
    endtask

    task automatic send_frame(input logic [31:0] src, input logic [31:0] dst, input logic [7:0] proto,
                              input bit bad, input int abort_at, output int stalls);
        int w;
        stalls = 0;
        @(posedge clk); #1;
        s_if.ip_hdr_valid = 1'b1;
        s_if.ip_protocol  = proto;
        s_if.ip_source_ip = src;
        s_if.ip_dest_ip   = dst;
        s_if.ip_length    = 16'(20 + frm.size());
        w = 0;
        forever begin
            @(negedge clk);
            if (s_if.ip_hdr_ready) break;
            if (++w > TMO) begin
                check("hdr_accept_timeout", 0, 1);
                s_if.ip_hdr_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        s_if.ip_hdr_valid = 1'b0;
        for (int i = 0; i < frm.size(); i++) begin
            if (i == abort_at) begin
                s_if.ip_payload_tvalid = 1'b0;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            s_if.ip_payload_tdata  = frm[i];
            s_if.ip_payload_tlast  = i == frm.size() - 1;
            s_if.ip_payload_tuser  = bad && i == frm.size() - 1;
            s_if.ip_payload_tvalid = 1'b1;
            w = 0;
            forever begin
                @(negedge clk);
                if (s_if.ip_payload_tready) break;
                stalls++;
                if (++w > TMO) begin
                    check("byte_accept_timeout", 0, 1);
                    s_if.ip_payload_tvalid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        s_if.ip_payload_tvalid = 1'b0;
        s_if.ip_payload_tlast  = 1'b0;
        s_if.ip_payload_tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_hdr.size() != 0 || exp_pay.size() != 0) && w < TMO) begin
            @(negedge clk);
            w++;
        end
        check("drain_left", 64'(exp_hdr.size() + exp_pay.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_s_ready"}, {s_if.ip_hdr_ready, s_if.ip_payload_tready}, 2'b10);
        check({tag, "_m_valid"}, {m_if.ip_hdr_valid, m_if.ip_payload_tvalid}, 2'b00);
        check({tag, "_counts"}, {reply_count, drop_count}, 32'd0);
    endtask

    // sink: drives the DUT's downstream readies just after each rising edge
    initial forever begin
        @(posedge clk); #1;
        m_if.ip_hdr_ready      = !sink_hold;
        m_if.ip_payload_tready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: scoreboard pops on every handshake, plus stall stability
    initial forever begin
        hdr_t h;
        logic [8:0] p;
        @(negedge clk);
        if (rst) begin
            prev_stall = 0;
            pay_seen   = 0;
            continue;
        end
        if (prev_stall) begin
            check("stall_hold_valid", m_if.ip_payload_tvalid, 1);
            check("stall_hold_data", {m_if.ip_payload_tuser, m_if.ip_payload_tlast, m_if.ip_payload_tdata}, prev_pay);
        end
        prev_stall = m_if.ip_payload_tvalid && !m_if.ip_payload_tready;
        prev_pay   = {m_if.ip_payload_tuser, m_if.ip_payload_tlast, m_if.ip_payload_tdata};
        if (m_if.ip_hdr_valid && m_if.ip_hdr_ready) begin
            if (exp_hdr.size() == 0) check("unexpected_hdr", 1, 0);
            else begin
                h = exp_hdr.pop_front();
                check("hdr_src", m_if.ip_source_ip, h.src);
                check("hdr_dst", m_if.ip_dest_ip, h.dst);
                check("hdr_len", m_if.ip_length, h.len);
                check("hdr_fields", {m_if.ip_dscp, m_if.ip_ecn, m_if.ip_ttl, m_if.ip_protocol},
                      {6'd0, 2'd0, 8'd64, 8'd1});
            end
        end
        if (m_if.ip_payload_tvalid && m_if.ip_payload_tready) begin
            if (exp_pay.size() == 0) check("unexpected_byte", 1, 0);
            else begin
                p = exp_pay.pop_front();
                check("pay_byte", {m_if.ip_payload_tuser, m_if.ip_payload_tlast, m_if.ip_payload_tdata}, {1'b0, p});
            end
            pay_seen = m_if.ip_payload_tlast ? 0 : pay_seen + 1;
        end
    end

    initial begin
        int st, st2;
        logic [15:0] hc;
        logic [15:0] t2_in  [3] = '{16'hF800, 16'hFFFF, 16'h0000};
        logic [15:0] t2_out [3] = '{16'h0001, 16'h0800, 16'h0800};
        logic [7:0]  t3_type[4] = '{8'h00, 8'h08, 8'h08, 8'h08};
        logic [7:0]  t3_code[4] = '{8'h00, 8'h01, 8'h00, 8'h00};
        int          t3_len [4] = '{40, 40, 6, 40};
        bit          t3_bad [4] = '{0, 0, 0, 1};
        s_if.ip_hdr_valid = 0;
        s_if.ip_dscp = 0;
        s_if.ip_ecn = 0;
        s_if.ip_ttl = 8'd64;
        s_if.ip_protocol = 8'h01;
        s_if.ip_length = 0;
        s_if.ip_source_ip = 0;
        s_if.ip_dest_ip = 0;
        s_if.ip_payload_tdata = 0;
        s_if.ip_payload_tvalid = 0;
        s_if.ip_payload_tlast = 0;
        s_if.ip_payload_tuser = 0;
        m_if.ip_hdr_ready = 1;
        m_if.ip_payload_tready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("reset");

        build(8'h08, 8'h00, 16'h4D5A, 64);
        push_reply(IP_A, IP_B, 16'h555A);
        send_frame(IP_A, IP_B, 8'h01, 0, -1, st);
        wait_drain();
        rep_exp++;
        check("t1_reply_count", reply_count, 64'(rep_exp));

        for (int i = 0; i < 3; i++) begin
            build(8'h08, 8'h00, t2_in[i], 8 + 4 * i);
            push_reply(IP_B, IP_A, t2_out[i]);
            send_frame(IP_B, IP_A, 8'h01, 0, -1, st);
            wait_drain();
            rep_exp++;
        end
        check("t2_reply_count", reply_count, 64'(rep_exp));

        for (int i = 0; i < 4; i++) begin
            build(t3_type[i], t3_code[i], 16'($urandom), t3_len[i]);
            send_frame(IP_A, IP_B, 8'h01, t3_bad[i], -1, st);
            check("t3_drop_stalls", 64'(st), 0);
            repeat (4) @(negedge clk);
            drop_exp++;
            check("t3_drop_count", drop_count, 64'(drop_exp));
        end
        build(8'h08, 8'h00, 16'h1234, 20);
        send_frame(IP_A, IP_B, 8'h06, 0, -1, st);
        repeat (4) @(negedge clk);
        drop_exp++;
        check("t3_proto_drop_count", drop_count, 64'(drop_exp));

        build(8'h08, 8'h00, 16'h1234, DEPTH + 1);
        send_frame(IP_A, IP_B, 8'h01, 0, -1, st);
        check("t4_oversize_stalls", 64'(st), 0);
        repeat (4) @(negedge clk);
        drop_exp++;
        check("t4_drop_count", drop_count, 64'(drop_exp));
        hc = 16'($urandom);
        build(8'h08, 8'h00, hc, 16);
        push_reply(IP_A, IP_B, cks_model(hc));
        send_frame(IP_A, IP_B, 8'h01, 0, -1, st);
        wait_drain();
        rep_exp++;
        check("t4_reply_count", reply_count, 64'(rep_exp));

        sink_hold = 1;
        hc = 16'($urandom);
        build(8'h08, 8'h00, hc, 64);
        push_reply(IP_A, IP_B, cks_model(hc));
        send_frame(IP_A, IP_B, 8'h01, 0, -1, st);
        hc = 16'($urandom);
        build(8'h08, 8'h00, hc, 24);
        push_reply(IP_B, IP_A, cks_model(hc));
        fork
            send_frame(IP_B, IP_A, 8'h01, 0, -1, st2);
            begin
                repeat (10) @(negedge clk);
                check("t5_second_hdr_blocked", s_if.ip_hdr_ready, 0);
                check("t5_reply_hdr_pending", m_if.ip_hdr_valid, 1);
                sink_hold = 0;
                sink_rand = 1;
            end
        join
        wait_drain();
        sink_rand = 0;
        rep_exp += 2;
        check("t5_reply_count", reply_count, 64'(rep_exp));

        build(8'h08, 8'h00, 16'($urandom), 40);
        send_frame(IP_A, IP_B, 8'h01, 0, 20, st);
        check_reset_values("t6_rx_reset");
        hc = 16'($urandom);
        build(8'h08, 8'h00, hc, 40);
        push_reply(IP_A, IP_B, cks_model(hc));
        send_frame(IP_A, IP_B, 8'h01, 0, -1, st);
        for (int w = 0; w < TMO && pay_seen < 10; w++) @(negedge clk);
        check("t6_reached_byte10", 64'(pay_seen >= 10), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_hdr.delete();
        exp_pay.delete();
        check_reset_values("t6_tx_reset");
        hc = 16'($urandom);
        build(8'h08, 8'h00, hc, 32);
        push_reply(IP_B, IP_A, cks_model(hc));
        send_frame(IP_B, IP_A, 8'h01, 0, -1, st);
        wait_drain();
        check("t6_counts_after", {reply_count, drop_count}, {16'd1, 16'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
